// File: rtl/uart_mon_pkg.sv
// Shared encodings for the hex-print UART feeder.
// UART_HEX_TX_CRLF_EN enables the CR+LF terminator.
package uart_mon_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DIGIT = 3'd1;
  localparam logic [2:0] ST_TERM1 = 3'd2;
  localparam logic [2:0] ST_TERM2 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  localparam logic [1:0] NIB_2  = 2'd0;
  localparam logic [1:0] NIB_4  = 2'd1;
  localparam logic [1:0] NIB_8  = 2'd2;
  localparam logic [1:0] NIB_8B = 2'd3;

  localparam logic [1:0] TERM_NONE  = 2'd0;
  localparam logic [1:0] TERM_SP    = 2'd1;
  localparam logic [1:0] TERM_CRLF  = 2'd2;
  localparam logic [1:0] TERM_NONE3 = 2'd3;

  function automatic logic [3:0] digit_cnt(
    input logic [1:0] nib
  );
    logic [3:0] c;
    case (nib)
      NIB_2:   c = 4'd2;
      NIB_4:   c = 4'd4;
      default: c = 4'd8;
    endcase
    return c;
  endfunction

  // Left-justify so the first digit is always in [31:28].
  function automatic logic [31:0] align(
    input logic [31:0] d,
    input logic [1:0]  nib
  );
    logic [31:0] a;
    case (nib)
      NIB_2:   a = {d[7:0], 24'h0};
      NIB_4:   a = {d[15:0], 16'h0};
      default: a = d;
    endcase
    return a;
  endfunction

  function automatic logic [1:0] term_norm(
    input logic [1:0] t
  );
    logic [1:0] r;
    case (t)
      TERM_SP: r = TERM_SP;
`ifdef UART_HEX_TX_CRLF_EN
      TERM_CRLF: r = TERM_CRLF;
`else
      TERM_CRLF: r = TERM_SP;
`endif
      default: r = TERM_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_nib2asc.sv
// Nibble to uppercase ASCII hex digit.
module hex_nib2asc
  import uart_mon_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    asc = ASC_0 + {4'h0, nib};
    if (nib > 4'd9) begin
      asc = ASC_A + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints a 2/4/8-digit hex value into a UART tx FIFO.
// UART_HEX_TX_CRLF_EN enables the CR+LF terminator.
module uart_hex_tx
  import uart_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_nib,
  input  logic [1:0]  req_term,
  output logic [7:0]  tx_wdata,
  output logic        tx_wten,
  input  logic        tx_fifo_full,
  output logic        done
);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [31:0] shreg;
  logic [1:0]  term;
  logic        busy;
  logic        wr;
  logic        accept;
  logic [7:0]  asc;

  hex_nib2asc u_nib2asc (
    .nib (shreg[31:28]),
    .asc (asc)
  );

  assign busy = (state == ST_DIGIT)
             || (state == ST_TERM1)
             || (state == ST_TERM2);
  assign wr   = busy && !tx_fifo_full;

  // Reset gates the outputs so an abort costs no extra write.
  assign tx_wten   = wr && !rst;
  assign done      = (state == ST_DONE) && !rst;
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    tx_wdata = 8'h00;
    case (state)
      ST_DIGIT: tx_wdata = asc;
`ifdef UART_HEX_TX_CRLF_EN
      ST_TERM1: tx_wdata =
        (term == TERM_CRLF) ? ASC_CR : ASC_SP;
      ST_TERM2: tx_wdata = ASC_LF;
`else
      ST_TERM1: tx_wdata = ASC_SP;
`endif
      default:  tx_wdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      shreg <= 32'h0;
      term  <= TERM_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= align(req_data, req_nib);
            cnt   <= digit_cnt(req_nib);
            term  <= term_norm(req_term);
            state <= ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (wr) begin
            shreg <= {shreg[27:0], 4'h0};
            cnt   <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= (term == TERM_NONE)
                     ? ST_DONE : ST_TERM1;
            end
          end
        end
        ST_TERM1: begin
          if (wr) begin
`ifdef UART_HEX_TX_CRLF_EN
            state <= (term == TERM_CRLF)
                   ? ST_TERM2 : ST_DONE;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef UART_HEX_TX_CRLF_EN
        ST_TERM2: begin
          if (wr) begin
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_hex_tx.md
UART_HEX_TX -- requirements
Module: uart_hex_tx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  print request strobe.
REQ-004 SHALL have ports: req_ready  out  1  block idle, request may be accepted.
REQ-005 SHALL have ports: req_data  in  32  value to print.
REQ-006 SHALL have ports: req_nib  in  2  digit count; 0 = 2 digits, 1 = 4, 2 = 8, 3 = 8.
REQ-007 SHALL have ports: req_term  in  2  terminator; 0 = none, 1 = space, 2 = CR+LF, 3 = none.
REQ-008 SHALL have ports: tx_wdata  out  8  ASCII byte to the UART tx FIFO.
REQ-009 SHALL have ports: tx_wten  out  1  tx FIFO write strobe, one byte per asserted cycle.
REQ-010 SHALL have ports: tx_fifo_full  in  1  tx FIFO full; no write is issued while high.
REQ-011 SHALL have ports: done  out  1  one-cycle pulse after the last byte of a request is written.
REQ-012 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-013 SHALL implement the FSM states IDLE, DIGIT, TERM1, TERM2 and DONE.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready.
REQ-015 SHALL on acceptance latch req_data, req_nib and req_term, load the digit counter with 2/4/8 and go to DIGIT.
REQ-016 SHALL ignore req_valid outside IDLE; inputs changing mid-operation have no effect.
REQ-017 SHALL in DIGIT assert tx_wten in every cycle where tx_fifo_full = 0, emitting the most significant remaining nibble first.
REQ-018 SHALL map nibbles 0-9 to 0x30-0x39 and A-F to 0x41-0x46 (uppercase).
REQ-019 SHALL issue the first tx_wten no earlier than the cycle after acceptance; with the FIFO never full, the output rate is one byte per cycle.
REQ-020 SHALL hold tx_wten low and all state unchanged while tx_fifo_full = 1 (stall); the stall has unbounded length.
REQ-021 SHALL decrement the digit counter on each digit write; after the final digit it SHALL go to TERM1 if a terminator is selected, else to DONE.
REQ-022 SHALL in TERM1 write 0x20 (space) or 0x0D (CR), then go to DONE for a space or to TERM2 for CR+LF; TERM2 SHALL write 0x0A, then go to DONE.
REQ-023 SHALL in DONE pulse done for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after done.
REQ-024 SHALL hold tx_wten = 0 and done = 0 in IDLE; tx_wdata is don't-care when tx_wten = 0.
REQ-025 SHALL never write while tx_fifo_full is high; this guarantees no tx FIFO overrun, given the FIFO's one-cycle full update.

Reset
REQ-026 SHALL on rst = 1 enter IDLE, clear the digit counter and latched data, and drive req_ready = 1 from the first cycle after reset, with tx_wten = 0 and done = 0.
REQ-027 SHALL when rst is asserted mid-request abort the request at once with no further writes and no done pulse.

Configuration
REQ-028 SHALL with UART_HEX_TX_CRLF_EN defined support req_term = 2 as CR+LF per REQ-022.
REQ-029 SHALL without UART_HEX_TX_CRLF_EN treat req_term = 2 as space, omit the TERM2 state logic, and never emit 0x0D or 0x0A.

Structure
REQ-030 SHALL place the FSM state encodings, the ASCII constants (0x20, 0x0D, 0x0A, 0x30, 0x41) and the req_nib/req_term encodings in the shared package uart_mon_pkg.
REQ-031 SHALL implement the nibble-to-ASCII mapping in a single combinational sub-module, hex_nib2asc.

Verification
REQ-032 SHALL cover: req_data = 0x1234ABCD, req_nib = 2, req_term = 0, FIFO never full -> bytes "1234ABCD" on 8 consecutive cycles, then done.
REQ-033 SHALL cover: req_data = 0x000000F0, req_nib = 0, req_term = 1 -> bytes 0x46, 0x30, 0x20, then a done pulse.
REQ-034 SHALL cover: req_data = 0xBEEF, req_nib = 1, req_term = 2, macro defined -> "BEEF", 0x0D, 0x0A; with the macro undefined -> "BEEF", 0x20.
REQ-035 SHALL cover: tx_fifo_full held high for 5 cycles after the 2nd digit -> no tx_wten during the stall, the 3rd digit is written correctly afterwards, and the total byte count is unchanged.
REQ-036 SHALL cover: rst pulsed after the 3rd digit of an 8-digit request -> no further tx_wten, no done pulse, req_ready = 1 on the next cycle, and a following request completes normally.
REQ-037 SHALL cover: req_valid held high continuously -> exactly one request is accepted per IDLE visit, and the 2nd request starts only after done.
